// File: rtl/mod_updown_counter.sv
// Synchronous up/down modulo counter with prescaler, parallel load, terminal count, wrap pulse and sticky overflow.
// Define COUNTER_SATURATE_EN to hold q at the boundary instead of wrapping around.
module mod_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             ovf_clr_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             wrap_o,
  output logic             ovf_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;

  logic atMax, atZero, stepNow, boundaryStep;

  assign atMax        = (count_q == MAX_VAL);
  assign atZero       = (count_q == '0);
  assign stepNow      = en_i && (presc_q == PRESC_LAST);
  assign boundaryStep = stepNow && (up_i ? atMax : atZero);

  // Load takes priority over counting; a boundary step always raises wrap and ovf.
  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q && !ovf_clr_i;
    if (load_i) begin
      count_d = (load_val_i > MAX_VAL) ? MAX_VAL : load_val_i;
      presc_d = '0;
    end else if (en_i) begin
      if (stepNow) begin
        presc_d = '0;
        if (boundaryStep) begin
          wrap_d = 1'b1;
          ovf_d  = 1'b1;
`ifdef COUNTER_SATURATE_EN
          count_d = count_q;
`else
          count_d = up_i ? '0 : MAX_VAL;
`endif
        end else begin
          count_d = up_i ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q_o    = count_q;
  assign tc_o   = up_i ? atMax : atZero;
  assign wrap_o = wrap_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: a default instance (4/16/1) and a modulus-10, prescale-3 instance.
module tb_mod_updown_counter;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       aEn, aUp, aLoad, aOvfClr;
  logic [3:0] aLoadVal;
  logic [3:0] aQ;
  logic       aTc, aWrap, aOvf;
  logic       bEn, bUp, bLoad, bOvfClr;
  logic [3:0] bLoadVal;
  logic [3:0] bQ;
  logic       bTc, bWrap, bOvf;

  int compared   = 0;
  int mismatched = 0;

  mod_updown_counter dutA (
    .clk(clk), .reset(reset), .en_i(aEn), .up_i(aUp), .load_i(aLoad),
    .load_val_i(aLoadVal), .ovf_clr_i(aOvfClr),
    .q_o(aQ), .tc_o(aTc), .wrap_o(aWrap), .ovf_o(aOvf)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dutB (
    .clk(clk), .reset(reset), .en_i(bEn), .up_i(bUp), .load_i(bLoad),
    .load_val_i(bLoadVal), .ovf_clr_i(bOvfClr),
    .q_o(bQ), .tc_o(bTc), .wrap_o(bWrap), .ovf_o(bOvf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drives one instance for a single clock edge; the other instance idles.
  task automatic applyStimulus(input bit selB, input logic en, input logic up,
                               input logic load, input logic [3:0] val, input logic clr);
    if (selB) begin
      bEn = en; bUp = up; bLoad = load; bLoadVal = val; bOvfClr = clr;
      aEn = 1'b0; aLoad = 1'b0; aOvfClr = 1'b0;
    end else begin
      aEn = en; aUp = up; aLoad = load; aLoadVal = val; aOvfClr = clr;
      bEn = 1'b0; bLoad = 1'b0; bOvfClr = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int expQ;
    reset = 1'b0;
    aEn = 0; aUp = 0; aLoad = 0; aLoadVal = 0; aOvfClr = 0;
    bEn = 0; bUp = 0; bLoad = 0; bLoadVal = 0; bOvfClr = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_aQ", int'(aQ), 0);
    checkOutput("rst_aWrap", int'(aWrap), 0);
    checkOutput("rst_aOvf", int'(aOvf), 0);
    checkOutput("rst_aTc_down", int'(aTc), 1);
    checkOutput("rst_bQ", int'(bQ), 0);
    reset = 1'b1;

    // Count up through a full modulus-16 cycle
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
      expQ = (i == 16) ? (SAT ? 15 : 0) : i;
      checkOutput("up_aQ", int'(aQ), expQ);
      checkOutput("up_aWrap", int'(aWrap), (i == 16) ? 1 : 0);
      checkOutput("up_aOvf", int'(aOvf), (i == 16) ? 1 : 0);
      checkOutput("up_aTc", int'(aTc), (expQ == 15) ? 1 : 0);
    end

    // Load with en=1: load wins, ovf untouched
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 1'b0);
    checkOutput("ld_aQ", int'(aQ), 15);
    checkOutput("ld_aWrap", int'(aWrap), 0);
    checkOutput("ld_aOvf", int'(aOvf), 1);
    checkOutput("tc_up_aTc", int'(aTc), 1);
    aUp = 1'b0;
    #1;
    checkOutput("tc_down_aTc", int'(aTc), 0);

    // Wrapping step with ovf_clr on the same edge: set wins
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    checkOutput("coll_aQ", int'(aQ), SAT ? 15 : 0);
    checkOutput("coll_aWrap", int'(aWrap), 1);
    checkOutput("coll_aOvf", int'(aOvf), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    checkOutput("clr_aOvf", int'(aOvf), 0);
    checkOutput("clr_aWrap", int'(aWrap), 0);
    checkOutput("clr_aQ", int'(aQ), SAT ? 15 : 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("rewrap_aOvf", int'(aOvf), 1);

    // Modulus 10, prescale 3, counting down from reset
    bUp = 1'b0;
    #1;
    checkOutput("dn_bTc", int'(bTc), 1);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      if (i < 3)       expQ = 0;
      else if (i < 6)  expQ = SAT ? 0 : 9;
      else             expQ = SAT ? 0 : 8;
      checkOutput("dn_bQ", int'(bQ), expQ);
      checkOutput("dn_bWrap", int'(bWrap), (i == 3 || (i == 6 && SAT)) ? 1 : 0);
    end
    checkOutput("dn_bOvf", int'(bOvf), 1);

    // en pattern 1,0,1,1 counting up: only the third enabled cycle steps
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("ps1_bQ", int'(bQ), SAT ? 0 : 8);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("ps0_bQ", int'(bQ), SAT ? 0 : 8);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("ps2_bQ", int'(bQ), SAT ? 0 : 8);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("ps3_bQ", int'(bQ), SAT ? 1 : 9);
    checkOutput("ps3_bTc", int'(bTc), SAT ? 0 : 1);

    // Clamped load mid-prescale resets the prescaler
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd12, 1'b0);
    checkOutput("clamp_bQ", int'(bQ), 9);
    checkOutput("clamp_bWrap", int'(bWrap), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("presc_clr_bQ", int'(bQ), 9);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("ld_step_bQ", int'(bQ), SAT ? 9 : 0);
    checkOutput("ld_step_bWrap", int'(bWrap), 1);

    // Reset low while counting is enabled
    reset = 1'b0;
    aEn = 1'b1; aUp = 1'b1; bEn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_aQ", int'(aQ), 0);
    checkOutput("mid_rst_aWrap", int'(aWrap), 0);
    checkOutput("mid_rst_aOvf", int'(aOvf), 0);
    checkOutput("mid_rst_bQ", int'(bQ), 0);
    checkOutput("mid_rst_bOvf", int'(bOvf), 0);
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised synchronous up/down modulo counter; successor to the 4-bit D-flip-flop ripple counter. All state changes on one clock edge, so there is no ripple skew between bits. Adds configurable width and modulus, direction control, parallel load, an enable-qualified prescaler, a terminal-count output, a wrap pulse and a sticky overflow flag. Used as the general event/timebase counter in the lab designs.

## Interface
- WIDTH, 4: counter width in bits.
- MODULUS, 16: count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2^WIDTH.
- PRESCALE, 1: number of enabled cycles per count step. Must be >= 1.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- en  in  1  count enable; advances the prescaler.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value to load.
- ovf_clr  in  1  clears the sticky overflow flag.
- q  out  WIDTH  current count.
- tc  out  1  terminal count, combinational.
- wrap  out  1  registered one-cycle boundary pulse.
- ovf  out  1  sticky overflow flag.

## Operation
- Update priority per edge: reset (low) > load > count step.
- Reset: q=0, prescaler=0, wrap=0, ovf=0.
- Load:
  - q <= load_val.
  - If load_val >= MODULUS, q <= MODULUS-1 instead (clamp).
  - Prescaler cleared to 0; wrap=0 that cycle.
  - ovf is unaffected; ovf_clr is still honoured in the same cycle.
- Prescaler:
  - Counts 0..PRESCALE-1 on cycles where en=1.
  - A step occurs on an edge with en=1 and prescaler==PRESCALE-1; the prescaler then returns to 0.
  - en=0 holds both the prescaler and q.
  - With PRESCALE=1, every enabled cycle is a step.
- Step, up=1: q+1; if q==MODULUS-1, q <= 0 (wrap).
- Step, up=0: q-1; if q==0, q <= MODULUS-1 (wrap).
- Direction is sampled only on the step edge. Changing up mid-prescale is legal.
- Arithmetic is WIDTH-bit; no intermediate overflow when MODULUS == 2^WIDTH.
- tc = up ? (q==MODULUS-1) : (q==0). It follows up combinationally.
- wrap: 1 for exactly the cycle after a wrapping step, i.e. alongside the wrapped q value; otherwise 0.
- ovf:
  - Set on any wrapping step; held until ovf_clr=1.
  - If ovf_clr and a wrapping step occur on the same edge, set wins (ovf=1).

## Timing
- q latency: 1 edge from load, or from the step-qualifying en cycle.
- wrap and ovf update on the same edge as q.
- tc has 0-cycle latency from q and up.
- Reset low mid-prescale or mid-load: reset wins and all state returns to reset values on that edge.
- load with en=1 on the same edge: load wins and no step occurs.

## Configuration
- COUNTER_SATURATE_EN, defined (saturating mode):
  - A step at the boundary (up at MODULUS-1, or down at 0) holds q.
  - wrap still pulses for one cycle, and ovf still sets.
- COUNTER_SATURATE_EN undefined: wrap-around behaviour as described above.
- Loading and tc are identical in both modes.

## Test plan
- Reset then count: reset=0 for 2 cycles, then reset=1, en=1, up=1, defaults → q steps 0,1,…,15,0; wrap=1 only with the q=0 after 15; ovf=1 from then on.
- Modulus and down count: MODULUS=10, up=0 from reset → q=0→9→8; wrap pulses with q=9; tc=1 while q=0.
- Prescaler: PRESCALE=3, en toggled 1,0,1,1 → q increments only on the third enabled cycle; en=0 cycles do not advance the prescaler.
- Load: MODULUS=10, load=1, load_val=12, en=1 → q=9, no step, prescaler=0. Then up=1 step → q=0, wrap=1.
- ovf collision: ovf=1, then ovf_clr=1 on the same edge as a wrapping step → ovf stays 1. Next cycle with ovf_clr=1 and no wrap → ovf=0.
- Saturate build (COUNTER_SATURATE_EN): up=1 at q=15 → q holds at 15, wrap pulses once, ovf=1; reset low mid-count → q=0, wrap=0, ovf=0 on the next edge.
